// File: rtl/fsm_out_gate.sv
// Key-protected output gate: forwards user_input only while OPEN, relocks
// automatically after a timeout, and enters a timed LOCKOUT after MAX_FAIL
// consecutive bad keys. The illegal encoding recovers to LOCKED.
module fsm_out_gate #(
    parameter int unsigned       DATA_W         = 3,
    parameter logic [DATA_W-1:0] KEY            = 3'b101,
    parameter int unsigned       OPEN_CYCLES    = 8,
    parameter int unsigned       MAX_FAIL       = 3,
    parameter int unsigned       LOCKOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] user_input,
    input  logic              unlock_req,
    input  logic [DATA_W-1:0] key_in,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic [1:0]        state_o,
    output logic              lockout,
    output logic              err_illegal
);

    localparam int unsigned TIMER_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES
                                                                       : LOCKOUT_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int unsigned FAIL_W    = $clog2(MAX_FAIL + 1);

    localparam logic [1:0] ST_LOCKED  = 2'b00;
    localparam logic [1:0] ST_OPEN    = 2'b01;
    localparam logic [1:0] ST_LOCKOUT = 2'b10;

    localparam logic [TIMER_W-1:0] OPEN_LOAD    = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
    localparam logic [FAIL_W-1:0]  FAIL_ONE     = FAIL_W'(1);
    localparam logic [FAIL_W-1:0]  FAIL_LIMIT   = FAIL_W'(MAX_FAIL);

    logic [1:0]         state_q,       state_d;
    logic [TIMER_W-1:0] timer_q,       timer_d;
    logic [FAIL_W-1:0]  fail_cnt_q,    fail_cnt_d;
    logic [DATA_W-1:0]  out_q,         out_d;
    logic               out_valid_q,   out_valid_d;
    logic               err_illegal_q, err_illegal_d;

    logic               key_good;
    logic               key_bad;
    logic               timer_zero;
    logic [FAIL_W-1:0]  fail_inc;
    logic               fail_hit;

    // Key qualification and bad-key accounting shared by LOCKED and OPEN.
    always_comb begin
        key_good   = unlock_req && (key_in == KEY);
        key_bad    = unlock_req && (key_in != KEY);
        timer_zero = (timer_q == '0);
        fail_inc   = fail_cnt_q + FAIL_ONE;
        fail_hit   = (fail_inc == FAIL_LIMIT);
    end

    // Next-state, timer, fail counter and output data.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        fail_cnt_d    = fail_cnt_q;
        out_d         = out_q;
        out_valid_d   = 1'b0;
        err_illegal_d = 1'b0;

        case (state_q)
            ST_LOCKED: begin
                out_d = '0;
                if (key_good) begin
                    state_d    = ST_OPEN;
                    timer_d    = OPEN_LOAD;
                    fail_cnt_d = '0;
                end else if (key_bad) begin
                    if (fail_hit) begin
                        state_d    = ST_LOCKOUT;
                        timer_d    = LOCKOUT_LOAD;
                        fail_cnt_d = '0;
                    end else begin
                        fail_cnt_d = fail_inc;
                    end
                end
            end

            ST_OPEN: begin
                if (key_bad) begin
                    // Bad key relocks at once; any same-cycle data is dropped.
                    out_d = '0;
                    if (fail_hit) begin
                        state_d    = ST_LOCKOUT;
                        timer_d    = LOCKOUT_LOAD;
                        fail_cnt_d = '0;
                    end else begin
                        state_d    = ST_LOCKED;
                        timer_d    = '0;
                        fail_cnt_d = fail_inc;
                    end
                end else if (key_good) begin
                    // Extension: reload the window and still forward data.
                    timer_d    = OPEN_LOAD;
                    fail_cnt_d = '0;
                    if (in_valid) begin
                        out_d       = user_input;
                        out_valid_d = 1'b1;
                    end
                end else if (timer_zero) begin
                    // Last OPEN cycle: the gate closes and out returns to 0.
                    state_d = ST_LOCKED;
                    out_d   = '0;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                    if (in_valid) begin
                        out_d       = user_input;
                        out_valid_d = 1'b1;
                    end
                end
            end

            ST_LOCKOUT: begin
                out_d = '0;
                if (timer_zero) begin
                    state_d = ST_LOCKED;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            default: begin
                // Illegal encoding: recover to a clean LOCKED state.
                state_d       = ST_LOCKED;
                timer_d       = '0;
                fail_cnt_d    = '0;
                out_d         = '0;
                err_illegal_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOCKED;
            timer_q       <= '0;
            fail_cnt_q    <= '0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            fail_cnt_q    <= fail_cnt_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    // State visibility taken straight from the state register.
    assign state_o     = state_q;
    assign lockout     = (state_q == ST_LOCKOUT);
    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_fsm_out_gate.sv
// Directed bench for fsm_out_gate: forwarded data is checked by a scoreboard
// monitor; state, timing and lockout behaviour are checked inline.
module tb_fsm_out_gate;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [2:0] user_input;
    logic       unlock_req;
    logic [2:0] key_in;
    logic [2:0] out;
    logic       out_valid;
    logic [1:0] state_o;
    logic       lockout;
    logic       err_illegal;

    int checks   = 0;
    int failures = 0;
    int cnt;

    logic [2:0] exp_q[$];
    logic [2:0] exp_v;

    localparam logic [2:0] GOOD = 3'b101;
    localparam logic [2:0] BAD  = 3'b000;

    fsm_out_gate dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .user_input  (user_input),
        .unlock_req  (unlock_req),
        .key_in      (key_in),
        .out         (out),
        .out_valid   (out_valid),
        .state_o     (state_o),
        .lockout     (lockout),
        .err_illegal (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Apply one cycle of inputs at a negedge; return at the next negedge.
    task automatic drive(input logic iv, input logic [2:0] ui, input logic ur,
                         input logic [2:0] k, input logic fwd);
        in_valid   = iv;
        user_input = ui;
        unlock_req = ur;
        key_in     = k;
        if (fwd) exp_q.push_back(ui);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
    endtask

    // Idle while OPEN, counting observed OPEN cycles.
    task automatic count_open(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (state_o != 2'b01) break;
            n++;
            idle();
        end
    endtask

    // Scoreboard monitor: every out_valid must match the oldest expected word.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got out=%0h with no expected data", out);
            end else begin
                exp_v = exp_q.pop_front();
                chk("sb_data", 32'(out), 32'(exp_v));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; user_input = '0; unlock_req = 1'b0; key_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_lockout", 32'(lockout), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);

        // Unlock, forward one word, then the 8-cycle window expires.
        drive(1'b1, 3'b011, 1'b0, 3'b000, 1'b0);
        chk("locked_ignores_data", 32'(out_valid), 32'd0);
        drive(1'b0, 3'b000, 1'b1, GOOD, 1'b0);
        chk("unlock_state", 32'(state_o), 32'd1);
        drive(1'b1, 3'b110, 1'b0, 3'b000, 1'b1);
        chk("fwd_out", 32'(out), 32'b110);
        idle();
        chk("hold_out", 32'(out), 32'b110);
        chk("hold_valid", 32'(out_valid), 32'd0);
        repeat (5) idle();
        chk("open_cycle8_state", 32'(state_o), 32'd1);
        idle();
        chk("timeout_state", 32'(state_o), 32'd0);
        chk("timeout_out", 32'(out), 32'd0);

        // Reset mid-OPEN, then an immediate correct key reopens.
        drive(1'b0, 3'b000, 1'b1, GOOD, 1'b0);
        drive(1'b1, 3'b011, 1'b0, 3'b000, 1'b1);
        rst = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
        rst = 1'b0;
        chk("midrst_state", 32'(state_o), 32'd0);
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 3'b000, 1'b1, GOOD, 1'b0);
        chk("reopen_state", 32'(state_o), 32'd1);
        count_open(cnt);
        chk("open_len", 32'(cnt), 32'd8);

        // Three bad keys -> LOCKOUT for 16 cycles, keys and data ignored.
        drive(1'b0, 3'b000, 1'b1, BAD, 1'b0);
        drive(1'b0, 3'b000, 1'b1, BAD, 1'b0);
        chk("two_bad_no_lockout", 32'(lockout), 32'd0);
        drive(1'b0, 3'b000, 1'b1, BAD, 1'b0);
        chk("lockout_on", 32'(lockout), 32'd1);
        chk("lockout_state", 32'(state_o), 32'd2);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (!lockout) break;
            cnt++;
            drive(cnt == 3, 3'b111, cnt == 5, GOOD, 1'b0);
        end
        chk("lockout_len", 32'(cnt), 32'd16);
        chk("after_lockout_state", 32'(state_o), 32'd0);
        drive(1'b0, 3'b000, 1'b1, GOOD, 1'b0);
        chk("post_lockout_open", 32'(state_o), 32'd1);
        count_open(cnt);
        chk("post_lockout_open_len", 32'(cnt), 32'd8);

        // Bad, bad, good, bad (in OPEN), bad -> fail count was cleared.
        drive(1'b0, 3'b000, 1'b1, BAD, 1'b0);
        drive(1'b0, 3'b000, 1'b1, BAD, 1'b0);
        drive(1'b0, 3'b000, 1'b1, GOOD, 1'b0);
        chk("mix_open", 32'(state_o), 32'd1);
        drive(1'b0, 3'b000, 1'b1, BAD, 1'b0);
        chk("mix_bad_in_open", 32'(state_o), 32'd0);
        drive(1'b0, 3'b000, 1'b1, BAD, 1'b0);
        chk("mix_no_lockout", 32'(lockout), 32'd0);
        chk("mix_state", 32'(state_o), 32'd0);

        // Extension on the 6th OPEN cycle, with simultaneous data.
        drive(1'b0, 3'b000, 1'b1, GOOD, 1'b0);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (state_o != 2'b01) break;
            cnt++;
            if (cnt == 6)       drive(1'b1, 3'b001, 1'b1, GOOD, 1'b1);
            else if (cnt == 10) drive(1'b1, 3'b011, 1'b0, 3'b000, 1'b1);
            else                idle();
        end
        chk("extend_len", 32'(cnt), 32'd14);

        // Bad key while OPEN drops same-cycle data and clears out.
        drive(1'b0, 3'b000, 1'b1, GOOD, 1'b0);
        drive(1'b1, 3'b111, 1'b0, 3'b000, 1'b1);
        chk("pre_bad_out", 32'(out), 32'b111);
        drive(1'b1, 3'b010, 1'b1, 3'b100, 1'b0);
        chk("bad_open_state", 32'(state_o), 32'd0);
        chk("bad_open_out", 32'(out), 32'd0);
        chk("bad_open_valid", 32'(out_valid), 32'd0);

        // Illegal encoding recovers to LOCKED and clears the fail count.
        force dut.state_q = 2'b11;
        #1;
        release dut.state_q;
        @(negedge clk);
        chk("illegal_err", 32'(err_illegal), 32'd1);
        chk("illegal_state", 32'(state_o), 32'd0);
        chk("illegal_out", 32'(out), 32'd0);
        idle();
        chk("illegal_err_pulse", 32'(err_illegal), 32'd0);
        drive(1'b0, 3'b000, 1'b1, BAD, 1'b0);
        drive(1'b0, 3'b000, 1'b1, BAD, 1'b0);
        chk("illegal_fail_cleared", 32'(lockout), 32'd0);

        repeat (2) idle();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
